score_display_ctrl: RTL
=======================

# score_display_ctrl

Scheduler for the shared seven-segment cathode bus that shows the game score. It captures a 16-bit binary score on a load strobe and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits onto anodes An3..An0, with a blanking guard between slots and leading-zero suppression. It sits between the game core's score output and the board's An/Ca..Cg/Dp pins, and replaces ad-hoc scan logic in the top level.

## Interface
- SCAN_DIV, 131072: Clk cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 1024: cycles at the start of each slot with all anodes off (anti-ghosting).
- Clk  input  1  system clock; all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Value  input  16  binary score; sampled only on an accepted Load.
- Load  input  1  single-cycle strobe requesting capture/convert of Value.
- Enable  input  1  1 = drive display; 0 = all anodes off (scan keeps running).
- Busy  output  1  conversion in progress.
- Overflow  output  1  last accepted Value was > 9999.
- An  output  4  active-low anodes; An[3] = most significant digit.
- Cathodes  output  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.

## Operation
- Loader:
  - Load while Busy=0 is accepted.
  - Load while Busy=1 sets a one-deep pending flag and overwrites the pending value register with Value. The latest value wins.
  - When a conversion finishes with the pending flag set, the next conversion starts on the following cycle from the pending value, and the flag clears.
- Capture: if Value > 9999, the converter receives 9999 and Overflow is set. Otherwise it receives Value and Overflow is cleared. Overflow updates together with the displayed digits, not at capture.
- Converter states:
  - IDLE: Busy=0.
  - SHIFT: 16 iterations of add-3-if-≥5 on each BCD nibble, then shift left one bit. Uses a 16-bit BCD register plus a 16-bit binary shift register.
  - COMMIT: copies the BCD result and Overflow into the display registers, then goes to IDLE, or to SHIFT if a load is pending.
- Display registers D3..D0 hold the previous score until COMMIT. The update is atomic, so all four digits change on the same edge.
- Scanner:
  - Slot counter runs 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0. Index k drives An[k].
  - An = 4'b1111 while slot count < BLANK_CYCLES or Enable=0. Otherwise An[k]=0 and all other anodes are 1.
- Leading-zero suppression:
  - Digit k is blanked (Cathodes = 8'b11111111) when k > 0 and D3..Dk are all zero.
  - D0 is always shown, so a score of 0 displays a single "0".
- Segment codes, {Ca..Cg,Dp} active-low:
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
- Dp is 1 (off) except on digit 0 when Overflow=1, where Dp=0.
- Cathodes are registered from the digit index and D registers, so they change on the same edge as An.

## Timing
- Reset values (Reset_n=0, asynchronous):
  - An=1111, Cathodes=11111111, Busy=0, Overflow=0.
  - D3..D0=0, slot counter=0, digit index=0, pending=0, converter state=IDLE.
- Load accepted at edge N:
  - Busy=1 after edge N.
  - SHIFT iterations on edges N+1..N+16.
  - COMMIT at edge N+17: new digits and Overflow are visible after N+17, and Busy=0 after N+17 unless a load is pending.
- Pending load: Busy stays 1 continuously. The chained conversion commits 17 cycles after the first COMMIT.
- Load on the same edge as COMMIT: treated as a pending load and chained.
- Scan period per digit is exactly SCAN_DIV cycles. The anode is active for SCAN_DIV-BLANK_CYCLES cycles of each slot.
- Enable changes take effect on An on the next edge. The scan phase is unaffected.
- Reset_n asserted mid-conversion aborts the conversion: no commit, display returns to reset values. Operation resumes on the first edge after Reset_n rises.

## Test plan
Benches use SCAN_DIV=8, BLANK_CYCLES=2.
- Reset then release with no Load → An cycles through 1110,1101,1011,0111 with 2 of every 8 cycles at 1111. Cathodes show "0" only on An0 and are 11111111 on An1..An3.
- Load with Value=1234 → Busy high for exactly 17 cycles. Digits then show 4,3,2,1 on An0..An3, with Cathodes 10011001/00001101/00100101/10011111.
- Load Value=12345 → digits 9,9,9,9 and Overflow=1. Dp=0 only while An0 is active.
- Load 7 then, 5 cycles later, Load 42 then Load 305 while Busy → 7 commits at +17. 305 commits 17 cycles after that. Busy never drops between the two. 42 is never displayed. Digits read "305", with An3 blank.
- Enable=0 for 20 cycles mid-scan → An=1111 throughout. After re-enable, the digit index continues from where it would have been.
- Reset_n pulsed low at SHIFT iteration 8 of Load 9999 → outputs return to reset values immediately. No commit occurs, and the display shows "0".

Source files
------------

// File: rtl/score_display_ctrl_if.sv
// Score/display bus between the game core and the seven-segment scheduler.
interface score_display_ctrl_if;
  logic [15:0] Value;
  logic        Load;
  logic        Enable;
  logic        Busy;
  logic        Overflow;
  logic [3:0]  An;
  logic [7:0]  Cathodes;

  // Game-core side
  modport master (
    output Value, Load, Enable,
    input  Busy, Overflow, An, Cathodes
  );

  // Display scheduler side
  modport slave (
    input  Value, Load, Enable,
    output Busy, Overflow, An, Cathodes
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Score capture, sequential binary-to-BCD conversion and multiplexed
// seven-segment scan with blanking guard and leading-zero suppression.
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV     = 131072,
  parameter int unsigned BLANK_CYCLES = 1024
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  score_display_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [15:0]      MAX_VAL   = 16'd9999;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       iter_q, iter_d;
  logic             conv_ovf_q, conv_ovf_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       cath_q, cath_d;

  logic [15:0]      adj;
  logic             start;
  logic [15:0]      start_val;
  logic             slot_wrap;
  logic [3:0]       digit;
  logic [7:0]       seg;
  logic             blank;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction)
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low {Ca..Cg,Dp} pattern for a decimal digit, Dp off
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'b00000011;
      4'd1:    c = 8'b10011111;
      4'd2:    c = 8'b00100101;
      4'd3:    c = 8'b00001101;
      4'd4:    c = 8'b10011001;
      4'd5:    c = 8'b01001001;
      4'd6:    c = 8'b01000001;
      4'd7:    c = 8'b00011111;
      4'd8:    c = 8'b00000001;
      4'd9:    c = 8'b00001001;
      default: c = 8'b11111111;
    endcase
    return c;
  endfunction

  // Converter state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Converter next state, loader and commit logic
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    conv_ovf_d = conv_ovf_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    adj        = dd_adjust(bcd_q);
    start      = 1'b0;
    start_val  = bus.Value;

    // A load during a conversion is parked; the newest value replaces older ones
    if (bus.Load && busy_q) begin
      pend_d     = 1'b1;
      pend_val_d = bus.Value;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.Load) start = 1'b1;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        ovf_d   = conv_ovf_q;
        state_d = S_IDLE;
        // A load arriving on the commit edge is newer than any parked value
        if (bus.Load) begin
          start     = 1'b1;
          start_val = bus.Value;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          start     = 1'b1;
          start_val = pend_val_q;
          pend_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture with saturation at 9999
    if (start) begin
      state_d    = S_SHIFT;
      bin_d      = (start_val > MAX_VAL) ? MAX_VAL : start_val;
      conv_ovf_d = (start_val > MAX_VAL);
      bcd_d      = '0;
      iter_d     = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Scan timing, anode selection and cathode pattern for the upcoming cycle
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    slot_d    = slot_wrap ? '0 : slot_q + CNT_W'(1);
    idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;

    an_d = 4'b1111;
    if (bus.Enable && (slot_d >= BLANK_END)) an_d[idx_d] = 1'b0;

    digit = disp_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd3:    blank = (disp_d[15:12] == 4'd0);
      2'd2:    blank = (disp_d[15:8]  == 8'd0);
      2'd1:    blank = (disp_d[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase

    seg = seg_code(digit);
    if (blank) begin
      cath_d = 8'hFF;
    end else begin
      cath_d    = seg;
      cath_d[0] = ~((idx_d == 2'd0) && ovf_d);
    end
  end

  // Datapath, display and scan registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      conv_ovf_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      slot_q     <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1111;
      cath_q     <= 8'hFF;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      conv_ovf_q <= conv_ovf_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Overflow = ovf_q;
  assign bus.An       = an_q;
  assign bus.Cathodes = cath_q;

endmodule
